// File: rtl/spdif_tx.sv
// S/PDIF (IEC 60958 consumer) transmitter: one-pair holding buffer, B/M/W preambles and biphase-mark line coding.
// Optional build macro SPDIF_TX_HOLD_ON_UNDERRUN_EN: repeat the last pair with V=0 on underrun instead of sending zeros with V=1.
module spdif_tx #(
    parameter int          SAMPLE_WIDTH = 24,
    parameter logic [31:0] CHAN_STATUS  = 32'h0000_0004
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    enable,
    input  logic                    bmc_tick,
    input  logic [SAMPLE_WIDTH-1:0] left_data,
    input  logic [SAMPLE_WIDTH-1:0] right_data,
    input  logic                    sample_valid,
    output logic                    sample_ready,
    output logic                    spdif_out,
    output logic                    block_start,
    output logic                    underrun
);

    // state   | meaning
    // IDLE    | line held at 0, waiting for the first bmc_tick while enabled
    // PRE     | half-cells 0..7 of a subframe: B/M/W preamble
    // PAYLOAD | half-cells 8..63: slots 4..31 (audio, V, U, C, P)
    typedef enum logic [1:0] {IDLE, PRE, PAYLOAD} state_t;

    localparam logic [7:0] PRE_B = 8'b1110_1000;
    localparam logic [7:0] PRE_M = 8'b1110_0010;
    localparam logic [7:0] PRE_W = 8'b1110_0100;

    state_t                  state, state_nxt;
    logic [5:0]              hc, hc_nxt;
    logic                    side, side_nxt;
    logic [7:0]              frame, frame_nxt;
    logic                    pre_inv, pre_inv_nxt;
    logic                    step, load, bit_nxt;
    logic                    buf_full, buf_full_nxt, accept;
    logic [SAMPLE_WIDTH-1:0] buf_l, buf_r, cur_l, cur_r, cur_smp;
    logic                    cur_v;
    logic [23:0]             aud;
    logic                    c_bit, parity;
    logic [31:0]             slots;
    logic [7:0]              pre_pat;
`ifdef SPDIF_TX_HOLD_ON_UNDERRUN_EN
    logic [SAMPLE_WIDTH-1:0] last_l, last_r;
`endif

    // Slot image of the subframe being sent, indexed by slot number.
    always_comb begin
        cur_smp = side ? cur_r : cur_l;
        aud     = 24'(cur_smp) << (24 - SAMPLE_WIDTH);
        c_bit   = (frame < 8'd32) ? CHAN_STATUS[frame[4:0]] : 1'b0;
        parity  = ^aud ^ cur_v ^ c_bit;
        slots   = {parity, c_bit, 1'b0, cur_v, aud, 4'b0000};
    end

    always_comb begin
        state_nxt = state;
        hc_nxt    = hc;
        side_nxt  = side;
        frame_nxt = frame;
        load      = 1'b0;
        step      = enable && bmc_tick;
        if (step) begin
            case (state)
                IDLE: begin
                    state_nxt = PRE;
                    hc_nxt    = 6'd0;
                    side_nxt  = 1'b0;
                    frame_nxt = 8'd0;
                    load      = 1'b1;
                end
                PRE: begin
                    hc_nxt = hc + 6'd1;
                    if (hc == 6'd7) state_nxt = PAYLOAD;
                end
                PAYLOAD: begin
                    hc_nxt = hc + 6'd1;
                    if (hc == 6'd63) begin
                        state_nxt = PRE;
                        side_nxt  = ~side;
                        load      = side;
                        if (side) frame_nxt = (frame == 8'd191) ? 8'd0 : frame + 8'd1;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end

        // Preamble polarity follows the line level left by the previous subframe.
        pre_inv_nxt = pre_inv;
        if (step && (state == IDLE || (state == PAYLOAD && hc == 6'd63)))
            pre_inv_nxt = spdif_out;

        pre_pat = side_nxt ? PRE_W : ((frame_nxt == 8'd0) ? PRE_B : PRE_M);
        if (state_nxt == PRE)
            bit_nxt = pre_pat[~hc_nxt[2:0]] ^ pre_inv_nxt;
        else if (!hc_nxt[0])
            bit_nxt = ~spdif_out;
        else
            bit_nxt = spdif_out ^ slots[hc_nxt[5:1]];

        accept       = sample_valid && sample_ready;
        buf_full_nxt = buf_full;
        if (load)   buf_full_nxt = 1'b0;
        if (accept) buf_full_nxt = 1'b1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            hc           <= 6'd0;
            side         <= 1'b0;
            frame        <= 8'd0;
            pre_inv      <= 1'b0;
            spdif_out    <= 1'b0;
            block_start  <= 1'b0;
            underrun     <= 1'b0;
            sample_ready <= 1'b0;
            buf_full     <= 1'b0;
            buf_l        <= '0;
            buf_r        <= '0;
            cur_l        <= '0;
            cur_r        <= '0;
            cur_v        <= 1'b0;
`ifdef SPDIF_TX_HOLD_ON_UNDERRUN_EN
            last_l       <= '0;
            last_r       <= '0;
`endif
        end else if (!enable) begin
            state        <= IDLE;
            hc           <= 6'd0;
            side         <= 1'b0;
            frame        <= 8'd0;
            pre_inv      <= 1'b0;
            spdif_out    <= 1'b0;
            block_start  <= 1'b0;
            underrun     <= 1'b0;
            sample_ready <= 1'b0;
            buf_full     <= 1'b0;
`ifdef SPDIF_TX_HOLD_ON_UNDERRUN_EN
            last_l       <= '0;
            last_r       <= '0;
`endif
        end else begin
            state        <= state_nxt;
            hc           <= hc_nxt;
            side         <= side_nxt;
            frame        <= frame_nxt;
            pre_inv      <= pre_inv_nxt;
            if (step) spdif_out <= bit_nxt;
            block_start  <= load && (frame_nxt == 8'd0);
            underrun     <= load && !buf_full;
            sample_ready <= !buf_full_nxt;
            buf_full     <= buf_full_nxt;
            if (accept) begin
                buf_l <= left_data;
                buf_r <= right_data;
            end
            if (load) begin
                if (buf_full) begin
                    cur_l  <= buf_l;
                    cur_r  <= buf_r;
                    cur_v  <= 1'b0;
`ifdef SPDIF_TX_HOLD_ON_UNDERRUN_EN
                    last_l <= buf_l;
                    last_r <= buf_r;
`endif
                end else begin
`ifdef SPDIF_TX_HOLD_ON_UNDERRUN_EN
                    cur_l <= last_l;
                    cur_r <= last_r;
                    cur_v <= 1'b0;
`else
                    cur_l <= '0;
                    cur_r <= '0;
                    cur_v <= 1'b1;
`endif
                end
            end
        end
    end

endmodule

// File: tb/tb_spdif_tx.sv
// Directed bench for spdif_tx: captures the BMC line per half-cell and decodes preambles and slots.
// Honours SPDIF_TX_HOLD_ON_UNDERRUN_EN when deciding what an underrun frame should carry.
module tb_spdif_tx;

    localparam int NSTREAM = 194;

    typedef struct packed {
        logic [23:0] l;
        logic [23:0] r;
        logic [23:0] exp_l;
        logic [23:0] exp_r;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        enable;
    logic        bmc_tick;
    logic [23:0] left_data;
    logic [23:0] right_data;
    logic        sample_valid;
    logic        sample_ready;
    logic        spdif_out;
    logic        block_start;
    logic        underrun;

    int   n_cmp = 0;
    int   n_err = 0;
    int   ur_cnt = 0;
    logic tick_on = 1'b0;
    logic mon_on = 1'b0;
    logic tick_seen = 1'b0;
    logic acc_seen = 1'b0;
    logic line_q[$];
    logic bs_q[$];
    vec_t drv_q[$];
    vec_t vt[5];

    spdif_tx #(.SAMPLE_WIDTH(24), .CHAN_STATUS(32'h0000_0004)) dut (
        .clk(clk), .reset_n(reset_n), .enable(enable), .bmc_tick(bmc_tick),
        .left_data(left_data), .right_data(right_data), .sample_valid(sample_valid),
        .sample_ready(sample_ready), .spdif_out(spdif_out), .block_start(block_start),
        .underrun(underrun)
    );

    always #5 clk = ~clk;

    initial begin
        logic ph;
        ph = 1'b0;
        bmc_tick = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            ph = ~ph;
            bmc_tick = tick_on && ph;
        end
    end

    always @(posedge clk) begin
        tick_seen <= bmc_tick;
        acc_seen  <= sample_valid && sample_ready;
    end

    always @(negedge clk) begin
        if (mon_on && tick_seen) begin
            line_q.push_back(spdif_out);
            bs_q.push_back(block_start);
        end
        if (mon_on && underrun) ur_cnt++;
    end

    initial begin
        sample_valid = 1'b0;
        left_data = '0;
        right_data = '0;
        forever begin
            @(negedge clk);
            if (acc_seen && drv_q.size() > 0) void'(drv_q.pop_front());
            if (drv_q.size() > 0) begin
                sample_valid = 1'b1;
                left_data    = drv_q[0].l;
                right_data   = drv_q[0].r;
            end else begin
                sample_valid = 1'b0;
            end
        end
    end

    task automatic finish_run();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic step_clk();
        @(negedge clk);
        #1;
    endtask

    task automatic timeout(input string tag);
        n_cmp++;
        n_err++;
        $display("FAIL timeout_%s: got no event, expected one within budget", tag);
        finish_run();
    endtask

    task automatic wait_caps(input int n, input string tag);
        int k = 0;
        while (line_q.size() < n && k < 60000) begin
            step_clk();
            k++;
        end
        if (line_q.size() < n) timeout(tag);
    endtask

    task automatic wait_ready(input logic val, input string tag);
        int k = 0;
        while (sample_ready !== val && k < 50) begin
            step_clk();
            k++;
        end
        if (sample_ready !== val) timeout(tag);
    endtask

    function automatic vec_t pair_for(input int f);
        vec_t v;
        if (f < 5) return vt[f];
        v.l = 24'(f * 7919) ^ 24'h3C5A96;
        v.r = ~v.l ^ 24'(f);
        v.exp_l = v.l;
        v.exp_r = v.r;
        return v;
    endfunction

    // Preamble relative to the level before it; slot bit = transition inside the slot.
    function automatic void decode(input int o, output logic [7:0] pre,
                                   output logic [27:0] b, output logic ok);
        logic prev;
        prev = (o == 0) ? 1'b0 : line_q[o-1];
        for (int k = 0; k < 8; k++) pre[7-k] = line_q[o+k] ^ prev;
        ok = 1'b1;
        for (int s = 4; s < 32; s++) begin
            b[s-4] = line_q[o+2*s] ^ line_q[o+2*s+1];
            if (line_q[o+2*s] == line_q[o+2*s-1]) ok = 1'b0;
        end
    endfunction

    task automatic check_frame(input int fi, input int fnum, input logic [23:0] el,
                               input logic [23:0] er, input logic ev);
        logic [7:0]  pre, exp_pre;
        logic [27:0] b;
        logic        ok;
        string       tag;
        for (int s = 0; s < 2; s++) begin
            decode(fi * 128 + s * 64, pre, b, ok);
            tag = $sformatf("f%0d_%s", fnum, (s == 1) ? "R" : "L");
            if (s == 1)                  exp_pre = 8'b1110_0100;
            else if (fnum % 192 == 0)    exp_pre = 8'b1110_1000;
            else                         exp_pre = 8'b1110_0010;
            check({tag, "_pre"},    32'(pre), 32'(exp_pre));
            check({tag, "_data"},   32'(b[23:0]), 32'((s == 1) ? er : el));
            check({tag, "_v"},      32'(b[24]), 32'(ev));
            check({tag, "_u"},      32'(b[25]), 32'(0));
            check({tag, "_c"},      32'(b[26]), 32'((fnum % 192) == 2));
            check({tag, "_parity"}, 32'(^b), 32'(0));
            check({tag, "_bmc"},    32'(ok), 32'(1));
        end
    endtask

    function automatic int count_bs();
        int n = 0;
        foreach (bs_q[i]) if (bs_q[i]) n++;
        return n;
    endfunction

    task automatic restart_capture();
        line_q.delete();
        bs_q.delete();
        ur_cnt = 0;
        mon_on = 1'b1;
        tick_on = 1'b1;
    endtask

    initial begin
        vec_t v;
        int   k;
        vt[0] = '{24'h800001, 24'h7FFFFF, 24'h800001, 24'h7FFFFF};
        vt[1] = '{24'h000000, 24'hFFFFFF, 24'h000000, 24'hFFFFFF};
        vt[2] = '{24'hA5A5A5, 24'h5A5A5A, 24'hA5A5A5, 24'h5A5A5A};
        vt[3] = '{24'h123456, 24'hFEDCBA, 24'h123456, 24'hFEDCBA};
        vt[4] = '{24'h000001, 24'h800000, 24'h000001, 24'h800000};

        reset_n = 1'b0;
        enable  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_spdif_out",    32'(spdif_out),    32'(0));
        check("rst_sample_ready", 32'(sample_ready), 32'(0));
        check("rst_block_start",  32'(block_start),  32'(0));
        check("rst_underrun",     32'(underrun),     32'(0));
        step_clk();
        reset_n = 1'b1;
        step_clk();
        step_clk();
        check("ready_disabled", 32'(sample_ready), 32'(0));

        // Long stream: block wrap, channel status, ordering.
        enable = 1'b1;
        step_clk();
        check("ready_after_enable", 32'(sample_ready), 32'(1));
        for (int f = 0; f < NSTREAM; f++) drv_q.push_back(pair_for(f));
        wait_ready(1'b0, "stream_fill");
        restart_capture();
        wait_caps(NSTREAM * 128, "stream");
        tick_on = 1'b0;
        check("stream_underrun_cnt", 32'(ur_cnt), 32'(0));
        check("stream_bs_count", 32'(count_bs()), 32'(2));
        check("stream_bs_f0", 32'(bs_q[0]), 32'(1));
        check("stream_bs_f192", 32'(bs_q[192*128]), 32'(1));
        for (int f = 0; f < NSTREAM; f++) begin
            v = pair_for(f);
            check_frame(f, f, v.exp_l, v.exp_r, 1'b0);
        end
        mon_on = 1'b0;
        enable = 1'b0;
        repeat (3) step_clk();

        // Disable at half-cell 40 of frame 1 right subframe, on a high line level.
        enable = 1'b1;
        step_clk();
        drv_q.push_back(pair_for(300));
        drv_q.push_back(pair_for(301));
        wait_ready(1'b0, "drop_fill");
        restart_capture();
        wait_caps(128 + 64 + 41, "drop_pos");
        k = 0;
        while (spdif_out !== 1'b1 && k < 4) begin
            wait_caps(line_q.size() + 1, "drop_high");
            k++;
        end
        check("drop_line_high", 32'(spdif_out), 32'(1));
        check("ready_before_drop", 32'(sample_ready), 32'(1));
        enable = 1'b0;
        @(posedge clk);
        #1;
        check("drop_spdif_out", 32'(spdif_out), 32'(0));
        check("drop_sample_ready", 32'(sample_ready), 32'(0));
        repeat (10) step_clk();
        check("idle_ignores_tick", 32'(spdif_out), 32'(0));
        tick_on = 1'b0;
        mon_on = 1'b0;
        repeat (2) step_clk();

        // Re-enable: restart at frame 0, then underrun in frame 5.
        enable = 1'b1;
        step_clk();
        check("ready_reenable", 32'(sample_ready), 32'(1));
        for (int i = 0; i < 5; i++) drv_q.push_back(vt[i]);
        wait_ready(1'b0, "ur_fill");
        restart_capture();
        k = 0;
        while (ur_cnt == 0 && k < 2000) begin
            step_clk();
            k++;
        end
        if (ur_cnt == 0) timeout("underrun_pulse");
        check("ur_at_frame5", 32'(line_q.size()), 32'(5 * 128 + 1));
        drv_q.push_back(pair_for(500));
        drv_q.push_back(pair_for(501));
        wait_caps(7 * 128, "ur_frames");
        tick_on = 1'b0;
        check("restart_bs_first", 32'(bs_q[0]), 32'(1));
        check("restart_bs_count", 32'(count_bs()), 32'(1));
        check("ur_count", 32'(ur_cnt), 32'(1));
        for (int f = 0; f < 5; f++) check_frame(f, f, vt[f].exp_l, vt[f].exp_r, 1'b0);
`ifdef SPDIF_TX_HOLD_ON_UNDERRUN_EN
        check_frame(5, 5, vt[4].exp_l, vt[4].exp_r, 1'b0);
`else
        check_frame(5, 5, 24'h000000, 24'h000000, 1'b1);
`endif
        v = pair_for(500);
        check_frame(6, 6, v.exp_l, v.exp_r, 1'b0);

        // Asynchronous reset mid-payload, between clock edges.
        tick_on = 1'b1;
        wait_caps(7 * 128 + 20, "rst_pos");
        k = 0;
        do begin
            @(posedge clk);
            #3;
            k++;
        end while (!(spdif_out === 1'b1 && sample_ready === 1'b1) && k < 200);
        check("pre_reset_active", 32'({spdif_out, sample_ready}), 32'(2'b11));
        reset_n = 1'b0;
        #1;
        check("arst_spdif_out",    32'(spdif_out),    32'(0));
        check("arst_sample_ready", 32'(sample_ready), 32'(0));
        check("arst_block_start",  32'(block_start),  32'(0));
        check("arst_underrun",     32'(underrun),     32'(0));
        tick_on = 1'b0;
        mon_on = 1'b0;
        repeat (3) step_clk();
        reset_n = 1'b1;
        step_clk();
        step_clk();
        check("ready_after_reset", 32'(sample_ready), 32'(1));
        drv_q.push_back(vt[0]);
        wait_ready(1'b0, "rst_fill");
        restart_capture();
        wait_caps(128, "rst_frame");
        tick_on = 1'b0;
        check("rst_bs_first", 32'(bs_q[0]), 32'(1));
        check("rst_bs_count", 32'(count_bs()), 32'(1));
        check("rst_ur_count", 32'(ur_cnt), 32'(0));
        check_frame(0, 0, vt[0].exp_l, vt[0].exp_r, 1'b0);

        finish_run();
    end

endmodule
